bus_dma_copier: RTL and testbench

Memory-mapped bus initiator that copies a block of 32-bit words from a source address range to a destination address range. It drives the same single-cycle bus interface that the CPU's MEM stage drives: Write_enable, Read_enable, WordorByte, SystemUse, Addr and Write_data out, with Read_data returned combinationally in the same cycle. It sits beside the CPU as a second bus master. Arbitration is external: the arbiter grants the bus to this block whenever `busy` is high.

---
 rtl/bus_dma_copier.sv | 123 ++++++++++++
 tb/tb_bus_dma_copier.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_copier.sv
// Word-copy bus initiator: alternates READ/WRITE cycles on a single-cycle bus,
// moving len words from src to dst, with abort and misalignment rejection.
module bus_dma_copier #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             sys_use,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done,
    output logic             Write_enable,
    output logic             Read_enable,
    output logic             WordorByte,
    output logic             SystemUse,
    output logic [31:0]      Addr,
    output logic [31:0]      Write_data,
    input  logic [31:0]      Read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_buf;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_words;
    logic             r_sys;
    logic             r_error;
    logic             r_aborted;

    logic w_rd;
    logic w_wr;
    logic w_misaligned;

    assign w_rd         = (r_state == S_READ);
    assign w_wr         = (r_state == S_WRITE);
    assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_buf     <= '0;
            r_rem     <= '0;
            r_words   <= '0;
            r_sys     <= 1'b0;
            r_error   <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_aborted <= 1'b0;
                        r_words   <= '0;
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else if (len == '0) begin
                            r_error <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_error <= 1'b0;
                            r_src   <= src_addr;
                            r_dst   <= dst_addr;
                            r_rem   <= len;
                            r_sys   <= sys_use;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // An aborted read is simply dropped; the buffer keeps its old value.
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_buf   <= Read_data;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_src   <= r_src + 32'd4;
                    r_dst   <= r_dst + 32'd4;
                    r_rem   <= r_rem - 1'b1;
                    r_words <= r_words + 1'b1;
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_rem == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decode purely from registered state so reset clears them at once.
    assign busy         = w_rd | w_wr;
    assign done         = (r_state == S_DONE);
    assign error        = r_error;
    assign aborted      = r_aborted;
    assign words_done   = r_words;
    assign Read_enable  = w_rd;
    assign Write_enable = w_wr;
    assign WordorByte   = w_rd | w_wr;
    assign SystemUse    = (w_rd | w_wr) & r_sys;
    assign Addr         = w_rd ? r_src : (w_wr ? r_dst : 32'd0);
    assign Write_data   = w_wr ? r_buf : 32'd0;

endmodule

// File: tb/tb_bus_dma_copier.sv
// Directed bench for bus_dma_copier with a 4 KB word memory model on the bus.
module tb_bus_dma_copier;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        sys_use = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, error, aborted;
    logic [15:0] words_done;
    logic        Write_enable, Read_enable, WordorByte, SystemUse;
    logic [31:0] Addr, Write_data, Read_data;

    bus_dma_copier #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .sys_use(sys_use), .abort(abort),
        .busy(busy), .done(done), .error(error), .aborted(aborted),
        .words_done(words_done), .Write_enable(Write_enable),
        .Read_enable(Read_enable), .WordorByte(WordorByte),
        .SystemUse(SystemUse), .Addr(Addr), .Write_data(Write_data),
        .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_dat = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    assign Read_data = mem[Addr[11:2]];

    always @(posedge clk) begin
        if (Write_enable) mem[Addr[11:2]] <= Write_data;
        else if (ld_en) mem[ld_idx] <= ld_dat;
        if (Read_enable) rd_cnt <= rd_cnt + 1;
        if (Write_enable) wr_cnt <= wr_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    int          busy_cnt, done_cnt, done_first, nlog;
    logic        d_err, d_abt;
    logic [15:0] d_wd;
    logic [31:0] addr_log [0:15];
    logic        su_log [0:15];
    int          rd0, wr0;

    localparam logic [31:0] SRC0 = 32'h11111111, SRC1 = 32'h22222222, SRC2 = 32'h33333333;
    localparam logic [31:0] SRC3 = 32'h44444444, SRC4 = 32'h55555555;

    task automatic load(input int idx, input logic [31:0] dat);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx[9:0]; ld_dat = dat;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic load_src();
        load(0, SRC0); load(1, SRC1); load(2, SRC2); load(3, SRC3); load(4, SRC4);
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic su);
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        src_addr = s; dst_addr = d; len = l; sys_use = su; start = 1'b1;
        @(posedge clk);
    endtask

    // Sample at negedge i (after edge E0+i), then set abort/start for edge E0+i+1.
    task automatic run(input int n, input int abort_at, input int start_at,
                       input logic [31:0] s2, input logic [31:0] d2);
        busy_cnt = 0; done_cnt = 0; done_first = -1; nlog = 0;
        d_err = 1'bx; d_abt = 1'bx; d_wd = 'x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if ((Read_enable || Write_enable) && nlog < 16) begin
                addr_log[nlog] = Addr; su_log[nlog] = SystemUse; nlog++;
            end
            if (done) begin
                if (done_cnt == 0) done_first = i;
                done_cnt++; d_err = error; d_abt = aborted; d_wd = words_done;
            end
            abort = (i == abort_at);
            start = (i == start_at);
            if (i == start_at) begin src_addr = s2; dst_addr = d2; end
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_flags", {30'd0, error, aborted}, 0);
        chk("rst_words", {16'd0, words_done}, 0);
        chk("rst_bus", {28'd0, Write_enable, Read_enable, WordorByte, SystemUse}, 0);
        chk("rst_addr", Addr, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_normal();
        load_src();
        load(32'h40, 0); load(32'h41, 0); load(32'h42, 0);
        do_start(32'h000, 32'h100, 16'd3, 1'b0);
        run(10, -1, -1, 0, 0);
        chk("norm_busy_cycles", busy_cnt, 6);
        chk("norm_done_cnt", done_cnt, 1);
        chk("norm_done_time", done_first, 6);
        chk("norm_words", {16'd0, d_wd}, 3);
        chk("norm_flags", {30'd0, d_err, d_abt}, 0);
        chk("norm_mem0", mem[32'h40], SRC0);
        chk("norm_mem1", mem[32'h41], SRC1);
        chk("norm_mem2", mem[32'h42], SRC2);
        chk("norm_idle_addr", Addr, 0);
    endtask

    task automatic test_zero_misaligned();
        do_start(32'h000, 32'h120, 16'd0, 1'b0);
        run(4, -1, -1, 0, 0);
        chk("zero_done_time", done_first, 0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_busy", busy_cnt, 0);
        chk("zero_err", {31'd0, d_err}, 0);
        chk("zero_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        load(32'h50, 32'hA5A5A5A5);
        do_start(32'h002, 32'h140, 16'd4, 1'b0);
        run(4, -1, -1, 0, 0);
        chk("mis_done_time", done_first, 0);
        chk("mis_err", {31'd0, d_err}, 1);
        chk("mis_busy", busy_cnt, 0);
        chk("mis_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        chk("mis_mem", mem[32'h50], 32'hA5A5A5A5);
    endtask

    task automatic test_abort();
        for (int k = 0; k < 5; k++) load(32'h80 + k, 32'hCAFE0000 + k);
        do_start(32'h000, 32'h200, 16'd5, 1'b0);
        run(10, 3, -1, 0, 0);
        chk("abt_done_cnt", done_cnt, 1);
        chk("abt_done_time", done_first, 4);
        chk("abt_flag", {31'd0, d_abt}, 1);
        chk("abt_err", {31'd0, d_err}, 0);
        chk("abt_words", {16'd0, d_wd}, 2);
        chk("abt_reads", rd_cnt - rd0, 2);
        chk("abt_writes", wr_cnt - wr0, 2);
        chk("abt_mem1", mem[32'h81], SRC1);
        chk("abt_mem2", mem[32'h82], 32'hCAFE0002);
    endtask

    task automatic test_start_while_busy();
        load(32'hE0, 32'h0BADF00D);
        do_start(32'h000, 32'h300, 16'd4, 1'b0);
        run(16, -1, 1, 32'h010, 32'h380);
        chk("swb_done_cnt", done_cnt, 1);
        chk("swb_busy", busy_cnt, 8);
        chk("swb_words", {16'd0, d_wd}, 4);
        chk("swb_flags", {30'd0, d_err, d_abt}, 0);
        chk("swb_mem0", mem[32'hC0], SRC0);
        chk("swb_mem3", mem[32'hC3], SRC3);
        chk("swb_other", mem[32'hE0], 32'h0BADF00D);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'h7FC; exp_a[1] = 32'hFFFFFFFC; exp_a[2] = 32'h800; exp_a[3] = 32'h0;
        do_start(32'h7FC, 32'hFFFFFFFC, 16'd2, 1'b1);
        run(8, -1, -1, 0, 0);
        chk("wrap_nacc", nlog, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap_addr%0d", k), addr_log[k], exp_a[k]);
            chk($sformatf("wrap_su%0d", k), {31'd0, su_log[k]}, 1);
        end
        chk("wrap_words", {16'd0, d_wd}, 2);
    endtask

    task automatic test_reset_mid();
        load_src();
        load(32'h140, 32'h5A5A5A5A);
        load(32'h180, 0); load(32'h181, 0); load(32'h182, 0);
        do_start(32'h000, 32'h500, 16'd3, 1'b1);
        #1 start = 1'b0;
        #2;
        chk("mid_in_read", {31'd0, Read_enable}, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_bus", {28'd0, Write_enable, Read_enable, WordorByte, SystemUse}, 0);
        chk("mid_addr", Addr, 0);
        chk("mid_done", {31'd0, done}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_idle", {30'd0, busy, done}, 0);
        chk("mid_mem", mem[32'h140], 32'h5A5A5A5A);
        do_start(32'h000, 32'h600, 16'd3, 1'b0);
        run(10, -1, -1, 0, 0);
        chk("mid_done_cnt", done_cnt, 1);
        chk("mid_words", {16'd0, d_wd}, 3);
        chk("mid_copy0", mem[32'h180], SRC0);
        chk("mid_copy2", mem[32'h182], SRC2);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_misaligned();
        test_abort();
        test_start_while_busy();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
